// File: rtl/crossbar_buffered.sv
// crossbar_buffered: N-in/N-out val/rdy crossbar with multicast, per-output FIFOs and drain-before-commit reconfig
module crossbar_buffered #(
    parameter int BIT_WIDTH = 32,
    parameter int N_INPUTS  = 2,
    parameter int N_OUTPUTS = 2,
    parameter int DEPTH     = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [N_INPUTS*BIT_WIDTH-1:0]               recv_msg,
    input  logic [N_INPUTS-1:0]                         recv_val,
    output logic [N_INPUTS-1:0]                         recv_rdy,
    output logic [N_OUTPUTS*BIT_WIDTH-1:0]              send_msg,
    output logic [N_OUTPUTS-1:0]                        send_val,
    input  logic [N_OUTPUTS-1:0]                        send_rdy,
    input  logic [N_OUTPUTS*($clog2(N_INPUTS)+1)-1:0]   control,
    input  logic                                        control_val,
    output logic                                        control_rdy,
    output logic [N_OUTPUTS*($clog2(N_INPUTS)+1)-1:0]   active_config,
    output logic                                        busy
);
    localparam int SEL_W = $clog2(N_INPUTS);
    localparam int CW    = SEL_W + 1;
    localparam int PW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNTW  = $clog2(DEPTH + 1);
    typedef enum logic {RUN, DRAIN} state_t;
    state_t                      state;
    logic [N_OUTPUTS*CW-1:0]     pending;
    logic [N_OUTPUTS-1:0]        en, full, empty, push, pop;
    logic [N_INPUTS-1:0]         fire, any_sel, blocked;
    logic [SEL_W-1:0]            sel    [N_OUTPUTS];
    logic [BIT_WIDTH-1:0]        din    [N_OUTPUTS];
    logic [PW-1:0]               wr_ptr [N_OUTPUTS];
    logic [PW-1:0]               rd_ptr [N_OUTPUTS];
    logic [CNTW-1:0]             cnt    [N_OUTPUTS];
    logic [BIT_WIDTH-1:0]        mem    [N_OUTPUTS][DEPTH];
    // An input is ready only when every enabled output listening to it can accept, so multicast stays atomic.
    always_comb begin
        any_sel = '0;
        blocked = '0;
        push    = '0;
        for (int j = 0; j < N_OUTPUTS; j++) begin
            sel[j]   = active_config[j*CW +: SEL_W];
            en[j]    = active_config[j*CW+SEL_W] && (int'(sel[j]) < N_INPUTS);
            full[j]  = cnt[j] == CNTW'(DEPTH);
            empty[j] = cnt[j] == '0;
            pop[j]   = !empty[j] && send_rdy[j];
            din[j]   = '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                if (en[j] && sel[j] == SEL_W'(i)) begin
                    any_sel[i] = 1'b1;
                    blocked[i] = blocked[i] | full[j];
                    din[j]     = recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
        recv_rdy = (reset && state == RUN) ? any_sel & ~blocked : '0;
        fire     = recv_val & recv_rdy;
        for (int j = 0; j < N_OUTPUTS; j++)
            for (int i = 0; i < N_INPUTS; i++)
                if (en[j] && sel[j] == SEL_W'(i) && fire[i]) push[j] = 1'b1;
    end
    always_comb begin
        for (int j = 0; j < N_OUTPUTS; j++) send_msg[j*BIT_WIDTH +: BIT_WIDTH] = mem[j][rd_ptr[j]];
    end
    assign send_val    = ~empty;
    assign control_rdy = reset && state == RUN;
    assign busy        = state == DRAIN;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            pending <= '0;
            for (int j = 0; j < N_OUTPUTS; j++) begin
                active_config[j*CW +: CW] <= {1'b1, SEL_W'(j % N_INPUTS)};
                wr_ptr[j] <= '0;
                rd_ptr[j] <= '0;
                cnt[j]    <= '0;
            end
        end else begin
            for (int j = 0; j < N_OUTPUTS; j++) begin
                if (push[j]) wr_ptr[j] <= wr_ptr[j] == PW'(DEPTH-1) ? '0 : wr_ptr[j] + 1'b1;
                if (pop[j])  rd_ptr[j] <= rd_ptr[j] == PW'(DEPTH-1) ? '0 : rd_ptr[j] + 1'b1;
                cnt[j] <= cnt[j] + CNTW'(push[j]) - CNTW'(pop[j]);
            end
            if (state == RUN) begin
                if (control_val && control_rdy) begin
                    pending <= control;
                    state   <= DRAIN;
                end
            end else if (empty == '1) begin
                active_config <= pending;
                state         <= RUN;
            end
        end
    end
    always_ff @(posedge clk) begin
        for (int j = 0; j < N_OUTPUTS; j++)
            if (push[j]) mem[j][wr_ptr[j]] <= din[j];
    end
endmodule

// File: tb/tb_crossbar_buffered.sv
// tb_crossbar_buffered: directed scenario tasks for crossbar_buffered with default parameters
module tb_crossbar_buffered;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] recv_msg = '0;
    logic [1:0]  recv_val = '0;
    logic [1:0]  recv_rdy;
    logic [63:0] send_msg;
    logic [1:0]  send_val;
    logic [1:0]  send_rdy = '0;
    logic [3:0]  control = '0;
    logic        control_val = 1'b0;
    logic        control_rdy;
    logic [3:0]  active_config;
    logic        busy;
    int errors = 0;
    int checks = 0;

    crossbar_buffered dut (
        .clk(clk), .reset(reset),
        .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
        .control(control), .control_val(control_val), .control_rdy(control_rdy),
        .active_config(active_config), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++; if (send_val !== 2'b00) begin errors++; $display("FAIL rst_send_val got=%b exp=00", send_val); end
        checks++; if (recv_rdy !== 2'b00) begin errors++; $display("FAIL rst_recv_rdy got=%b exp=00", recv_rdy); end
        checks++; if (control_rdy !== 1'b0) begin errors++; $display("FAIL rst_control_rdy got=%b exp=0", control_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (active_config !== 4'b1110) begin errors++; $display("FAIL rst_config got=%b exp=1110", active_config); end
        step();
        reset = 1'b1;
        #1;
        checks++; if (control_rdy !== 1'b1) begin errors++; $display("FAIL post_rst_control_rdy got=%b exp=1", control_rdy); end
        checks++; if (recv_rdy !== 2'b11) begin errors++; $display("FAIL post_rst_recv_rdy got=%b exp=11", recv_rdy); end
    endtask

    task automatic test_stream();
        send_rdy = 2'b11;
        recv_val = 2'b11;
        recv_msg = {32'hB, 32'hA};
        step();
        checks++; if (send_val !== 2'b11) begin errors++; $display("FAIL stream_val1 got=%b exp=11", send_val); end
        checks++; if (send_msg !== {32'hB, 32'hA}) begin errors++; $display("FAIL stream_msg1 got=%h exp=%h", send_msg, {32'hB, 32'hA}); end
        recv_msg = {32'hD, 32'hC};
        step();
        checks++; if (send_msg !== {32'hD, 32'hC}) begin errors++; $display("FAIL stream_msg2 got=%h exp=%h", send_msg, {32'hD, 32'hC}); end
        checks++; if (recv_rdy !== 2'b11) begin errors++; $display("FAIL stream_rdy got=%b exp=11", recv_rdy); end
        recv_val = 2'b00;
        step();
        checks++; if (send_val !== 2'b00) begin errors++; $display("FAIL stream_drained got=%b exp=00", send_val); end
    endtask

    task automatic test_reconfig_empty();
        control = 4'b1010;
        control_val = 1'b1;
        step();
        control_val = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rce_busy got=%b exp=1", busy); end
        checks++; if (control_rdy !== 1'b0) begin errors++; $display("FAIL rce_control_rdy got=%b exp=0", control_rdy); end
        checks++; if (active_config !== 4'b1110) begin errors++; $display("FAIL rce_cfg_old got=%b exp=1110", active_config); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rce_busy_end got=%b exp=0", busy); end
        checks++; if (active_config !== 4'b1010) begin errors++; $display("FAIL rce_cfg_new got=%b exp=1010", active_config); end
    endtask

    task automatic test_multicast();
        send_rdy = 2'b01;
        recv_val = 2'b01;
        recv_msg = {32'h0, 32'h1};
        #1;
        checks++; if (recv_rdy !== 2'b01) begin errors++; $display("FAIL mc_rdy0 got=%b exp=01", recv_rdy); end
        step();
        checks++; if (send_msg !== {32'h1, 32'h1}) begin errors++; $display("FAIL mc_head1 got=%h exp=%h", send_msg, {32'h1, 32'h1}); end
        recv_msg = {32'h0, 32'h2};
        step();
        checks++; if (recv_rdy !== 2'b00) begin errors++; $display("FAIL mc_full_rdy got=%b exp=00", recv_rdy); end
        checks++; if (send_msg !== {32'h1, 32'h2}) begin errors++; $display("FAIL mc_head2 got=%h exp=%h", send_msg, {32'h1, 32'h2}); end
        recv_msg = {32'h0, 32'h3};
        step();
        checks++; if (send_val !== 2'b10) begin errors++; $display("FAIL mc_val3 got=%b exp=10", send_val); end
        checks++; if (recv_rdy !== 2'b00) begin errors++; $display("FAIL mc_stall_rdy got=%b exp=00", recv_rdy); end
        send_rdy = 2'b11;
        #1;
        checks++; if (recv_rdy !== 2'b00) begin errors++; $display("FAIL mc_full_pop_rdy got=%b exp=00", recv_rdy); end
        step();
        checks++; if (recv_rdy !== 2'b01) begin errors++; $display("FAIL mc_resume_rdy got=%b exp=01", recv_rdy); end
        checks++; if (send_msg[63:32] !== 32'h2) begin errors++; $display("FAIL mc_out1_2 got=%h exp=2", send_msg[63:32]); end
        step();
        recv_val = 2'b00;
        checks++; if (send_msg !== {32'h3, 32'h3} || send_val !== 2'b11) begin errors++; $display("FAIL mc_head3 got=%h/%b exp=%h/11", send_msg, send_val, {32'h3, 32'h3}); end
        step();
        checks++; if (send_val !== 2'b00) begin errors++; $display("FAIL mc_empty got=%b exp=00", send_val); end
    endtask

    task automatic test_reconfig_inflight();
        send_rdy = 2'b00;
        recv_val = 2'b01;
        recv_msg = {32'h0, 32'h11};
        step();
        recv_msg = {32'h0, 32'h22};
        step();
        recv_val = 2'b00;
        checks++; if (send_val !== 2'b11) begin errors++; $display("FAIL rci_queued got=%b exp=11", send_val); end
        control = 4'b1011;
        control_val = 1'b1;
        step();
        control_val = 1'b0;
        checks++; if (busy !== 1'b1 || recv_rdy !== 2'b00) begin errors++; $display("FAIL rci_drain got=busy%b/rdy%b exp=busy1/rdy00", busy, recv_rdy); end
        send_rdy = 2'b11;
        step();
        checks++; if (send_msg !== {32'h22, 32'h22}) begin errors++; $display("FAIL rci_pop1 got=%h exp=%h", send_msg, {32'h22, 32'h22}); end
        step();
        checks++; if (busy !== 1'b1 || active_config !== 4'b1010 || send_val !== 2'b00) begin errors++; $display("FAIL rci_last_pop got=busy%b/cfg%b/val%b exp=busy1/cfg1010/val00", busy, active_config, send_val); end
        step();
        checks++; if (busy !== 1'b0 || active_config !== 4'b1011) begin errors++; $display("FAIL rci_commit got=busy%b/cfg%b exp=busy0/cfg1011", busy, active_config); end
        recv_msg = {32'h55, 32'h66};
        recv_val = 2'b11;
        #1;
        checks++; if (recv_rdy !== 2'b11) begin errors++; $display("FAIL rci_new_rdy got=%b exp=11", recv_rdy); end
        step();
        recv_val = 2'b00;
        checks++; if (send_msg !== {32'h66, 32'h55}) begin errors++; $display("FAIL rci_route got=%h exp=%h", send_msg, {32'h66, 32'h55}); end
        step();
    endtask

    task automatic test_disabled();
        control = 4'b0010;
        control_val = 1'b1;
        step();
        control_val = 1'b0;
        step();
        send_rdy = 2'b00;
        recv_val = 2'b11;
        recv_msg = {32'hE1, 32'hE0};
        #1;
        checks++; if (recv_rdy !== 2'b01) begin errors++; $display("FAIL dis_rdy got=%b exp=01", recv_rdy); end
        step();
        checks++; if (send_val !== 2'b01) begin errors++; $display("FAIL dis_val got=%b exp=01", send_val); end
        step();
        checks++; if (recv_rdy !== 2'b00 || send_msg[31:0] !== 32'hE0) begin errors++; $display("FAIL dis_full got=rdy%b/head%h exp=rdy00/headE0", recv_rdy, send_msg[31:0]); end
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b0;
        #1;
        checks++; if (send_val !== 2'b00 || recv_rdy !== 2'b00) begin errors++; $display("FAIL ar_outputs got=val%b/rdy%b exp=val00/rdy00", send_val, recv_rdy); end
        checks++; if (active_config !== 4'b1110) begin errors++; $display("FAIL ar_config got=%b exp=1110", active_config); end
        #2;
        reset = 1'b1;
        recv_val = 2'b00;
        #1;
        checks++; if (send_val !== 2'b00 || recv_rdy !== 2'b11 || control_rdy !== 1'b1) begin errors++; $display("FAIL ar_release got=val%b/rdy%b/crdy%b exp=val00/rdy11/crdy1", send_val, recv_rdy, control_rdy); end
        step();
        checks++; if (send_val !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL ar_idle got=val%b/busy%b exp=val00/busy0", send_val, busy); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reconfig_empty();
        test_multicast();
        test_reconfig_inflight();
        test_disabled();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
